// File: rtl/axi_sched_pkg.sv
// axi_sched_pkg: shared FSM type, direction and 4 KB constants, clog2 helper for axi_burst_sched
package axi_sched_pkg;
    typedef enum logic [1:0] {IDLE, ARB, REQ, BURST} state_e;
    localparam int DIR_WR = 0;
    localparam int DIR_RD = 1;
    localparam int AXI_4K_BYTES = 4096;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/axi_burst_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
    import axi_sched_pkg::*;
#(
    parameter int N = 2,
    localparam int W = clog2(N) > 0 ? clog2(N) : 1
)(
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    int c;
    logic found;
    always_comb begin
        gnt = '0;
        idx = '0;
        found = 1'b0;
        c = 0;
        for (int i = 0; i < N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && req[c]) begin
                found = 1'b1;
                gnt[c] = 1'b1;
                idx = W'(c);
            end
        end
    end
endmodule

// File: rtl/axi_burst_sched.sv
// axi_burst_sched: round-robin AXI burst scheduler over per-channel address rings.
// Define AXI_SCHED_4K_SPLIT_EN to also clip bursts at 4 KB boundaries.
module axi_burst_sched
    import axi_sched_pkg::*;
#(
    parameter int CH_NUM = 2,
    parameter int ADDR_W = 30,
    parameter int LEN_W = 8,
    parameter int CNT_W = 10,
    parameter int DATA_BYTES = 8,
    parameter int DIR = DIR_WR,
    localparam int CW = clog2(CH_NUM) > 0 ? clog2(CH_NUM) : 1
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_NUM-1:0]        ch_en,
    input  logic [CH_NUM-1:0]        ch_clr,
    input  logic [CH_NUM*ADDR_W-1:0] cfg_beg_addr,
    input  logic [CH_NUM*ADDR_W-1:0] cfg_end_addr,
    input  logic [LEN_W-1:0]         cfg_burst_len,
    input  logic [CH_NUM*CNT_W-1:0]  fifo_level,
    input  logic                     m_ready,
    input  logic                     m_done,
    output logic                     m_start,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [LEN_W-1:0]         m_len,
    output logic [CW-1:0]            m_ch,
    output logic [CH_NUM-1:0]        ch_sel,
    output logic                     busy
);
    localparam int OFF = clog2(DATA_BYTES);
    localparam int BW = LEN_W + 1;
    if ((DIR != DIR_WR && DIR != DIR_RD) || (DATA_BYTES & (DATA_BYTES - 1)) != 0) begin : g_bad_cfg
        $error("axi_burst_sched: DIR must be 0/1 and DATA_BYTES a power of two");
    end
    state_e state_q, state_d;
    logic load_q;
    logic [ADDR_W-1:0] addr_q [CH_NUM];
    logic [ADDR_W-1:0] addr_d [CH_NUM];
    logic [ADDR_W-1:0] beg_a [CH_NUM];
    logic [ADDR_W-1:0] end_a [CH_NUM];
    logic [BW-1:0] beats [CH_NUM];
    logic [BW-1:0] eff_len [CH_NUM];
    logic [ADDR_W-1:0] span, nxt, inc, m_addr_q, m_addr_d;
    logic [BW-1:0] nom;
    logic [LEN_W-1:0] m_len_q, m_len_d;
    logic [CW-1:0] ptr_q, ptr_d, m_ch_q, m_ch_d, gnt_idx;
    logic [CH_NUM-1:0] ch_sel_q, ch_sel_d, clr_pend_q, clr_pend_d, elig, gnt, own;
`ifdef AXI_SCHED_4K_SPLIT_EN
    logic [12:0] lim;
`endif

    rr_arbiter #(.N(CH_NUM)) u_arb (.req(elig), .ptr(ptr_q), .gnt(gnt), .idx(gnt_idx));

    always_comb begin
        span = '0;
        elig = '0;
        nom = BW'(cfg_burst_len) + BW'(1);
`ifdef AXI_SCHED_4K_SPLIT_EN
        lim = '0;
`endif
        for (int c = 0; c < CH_NUM; c++) begin
            beg_a[c] = cfg_beg_addr[c*ADDR_W +: ADDR_W];
            end_a[c] = cfg_end_addr[c*ADDR_W +: ADDR_W];
            span = (end_a[c] - addr_q[c]) >> OFF;
            beats[c] = (addr_q[c] >= end_a[c]) ? '0 :
                       (span > ADDR_W'(1 << LEN_W)) ? BW'(1 << LEN_W) : BW'(span);
            eff_len[c] = (nom < beats[c]) ? nom : beats[c];
`ifdef AXI_SCHED_4K_SPLIT_EN
            lim = (13'(AXI_4K_BYTES) - {1'b0, addr_q[c][11:0]}) >> OFF;
            if (int'(lim) < int'(eff_len[c])) eff_len[c] = BW'(lim);
`endif
            elig[c] = ch_en[c] && !load_q && beats[c] != '0 &&
                      int'(fifo_level[c*CNT_W +: CNT_W]) >= int'(eff_len[c]);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        m_ch_d = m_ch_q;
        ch_sel_d = ch_sel_q;
        m_addr_d = m_addr_q;
        m_len_d = m_len_q;
        own = (state_q == ARB) ? gnt : ch_sel_q;
        clr_pend_d = clr_pend_q | (ch_clr & own);
        unique case (state_q)
            IDLE: if (|elig && m_ready) state_d = ARB;
            ARB: begin
                state_d = |elig ? REQ : IDLE;
                if (|elig) begin
                    m_ch_d = gnt_idx;
                    ch_sel_d = gnt;
                    m_addr_d = addr_q[gnt_idx];
                    m_len_d = LEN_W'(eff_len[gnt_idx] - BW'(1));
                    ptr_d = (gnt_idx == CW'(CH_NUM - 1)) ? '0 : gnt_idx + CW'(1);
                end
            end
            REQ: if (!m_ready) state_d = BURST;
            BURST: if (m_done) begin
                state_d = IDLE;
                ch_sel_d = '0;
                clr_pend_d = '0;
            end
            default: state_d = IDLE;
        endcase
        inc = (ADDR_W'(m_len_q) + ADDR_W'(1)) << OFF;
        nxt = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            addr_d[c] = addr_q[c];
            nxt = addr_q[c] + inc;
            if (load_q || (!own[c] && (ch_clr[c] || addr_q[c] >= end_a[c])))
                addr_d[c] = beg_a[c];
            else if (state_q == BURST && m_done && own[c])
                addr_d[c] = (clr_pend_q[c] || ch_clr[c] || nxt >= end_a[c]) ? beg_a[c] : nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            load_q <= 1'b1;
            ptr_q <= '0;
            m_ch_q <= '0;
            ch_sel_q <= '0;
            clr_pend_q <= '0;
            m_addr_q <= '0;
            m_len_q <= '0;
            for (int c = 0; c < CH_NUM; c++) addr_q[c] <= '0;
        end else begin
            state_q <= state_d;
            load_q <= 1'b0;
            ptr_q <= ptr_d;
            m_ch_q <= m_ch_d;
            ch_sel_q <= ch_sel_d;
            clr_pend_q <= clr_pend_d;
            m_addr_q <= m_addr_d;
            m_len_q <= m_len_d;
            for (int c = 0; c < CH_NUM; c++) addr_q[c] <= addr_d[c];
        end
    end

    assign m_start = state_q == REQ;
    assign busy = state_q != IDLE;
    assign m_addr = m_addr_q;
    assign m_len = m_len_q;
    assign m_ch = m_ch_q;
    assign ch_sel = ch_sel_q;
endmodule

// File: tb/tb_axi_burst_sched.sv
// tb_axi_burst_sched: table vectors plus corner sequences, bursts checked through a scoreboard queue
module tb_axi_burst_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] ch_en = '0, ch_clr = '0;
    logic [59:0] cfg_beg_addr = '0, cfg_end_addr = '0;
    logic [7:0] cfg_burst_len = 8'd15;
    logic [19:0] fifo_level = '0;
    logic m_ready, m_done;
    logic m_start, busy;
    logic [29:0] m_addr;
    logic [7:0] m_len;
    logic [0:0] m_ch;
    logic [1:0] ch_sel;

    axi_burst_sched dut (
        .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .ch_clr(ch_clr),
        .cfg_beg_addr(cfg_beg_addr), .cfg_end_addr(cfg_end_addr), .cfg_burst_len(cfg_burst_len),
        .fifo_level(fifo_level), .m_ready(m_ready), .m_done(m_done), .m_start(m_start),
        .m_addr(m_addr), .m_len(m_len), .m_ch(m_ch), .ch_sel(ch_sel), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef AXI_SCHED_4K_SPLIT_EN
    localparam logic [7:0] L4K = 8'd7;
`else
    localparam logic [7:0] L4K = 8'd15;
`endif

    typedef struct {
        int ch;
        logic [29:0] addr;
        logic [7:0] len;
    } burst_t;

    typedef struct {
        logic [29:0] b0, e0, b1, e1;
        logic [7:0] bl;
        logic [1:0] en;
        logic [9:0] l0, l1;
        bit go;
        int ch;
        logic [29:0] addr;
        logic [7:0] len;
    } vec_t;

    burst_t exp_q[$];
    int n_chk = 0, n_fail = 0, acc_cnt = 0;
    bit mst_en = 1'b1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int ch, logic [29:0] a, logic [7:0] l);
        exp_q.push_back('{ch, a, l});
    endtask

    initial begin
        burst_t e;
        int nb;
        m_ready = 1'b1;
        m_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mst_en && m_start && m_ready) begin
                acc_cnt++;
                chk("sb_pending", 64'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("m_ch", 64'(m_ch), 64'(e.ch));
                    chk("m_addr", 64'(m_addr), 64'(e.addr));
                    chk("m_len", 64'(m_len), 64'(e.len));
                    chk("ch_sel", 64'(ch_sel), 64'(2'b01 << e.ch));
                end
                nb = int'(m_len) + 1;
                @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (nb) @(posedge clk);
                #1 m_done = 1'b1;
                @(posedge clk);
                #1 m_done = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    task automatic rst_apply(logic [29:0] b0, e0, b1, e1, logic [7:0] bl, logic [1:0] en,
                             logic [9:0] l0, l1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        ch_en = '0;
        ch_clr = '0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outs", 64'({m_start, busy, ch_sel, m_len, m_ch, m_addr}), 0);
        cfg_beg_addr = {b1, b0};
        cfg_end_addr = {e1, e0};
        cfg_burst_len = bl;
        fifo_level = {l1, l0};
        ch_en = en;
        rst_n = 1'b1;
    endtask

    task automatic wait_acc(int target, int budget);
        int k = 0;
        while (acc_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("accept_count", 64'(acc_cnt), 64'(target));
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while ((busy || !m_ready) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 64'(k < budget), 1);
    endtask

    task automatic no_start(string name, int cycles);
        int base = acc_cnt;
        repeat (cycles) @(negedge clk);
        chk(name, 64'(acc_cnt), 64'(base));
    endtask

    vec_t tv [14];

    initial begin
        int k;
        tv[0]  = '{30'h0,   30'h200,    30'h1000, 30'h1100, 8'd15,  2'b11, 10'd20,   10'd0,  1'b1, 0, 30'h0,    8'd15};
        tv[1]  = '{30'h0,   30'h200,    30'h1000, 30'h1100, 8'd15,  2'b11, 10'd0,    10'd20, 1'b1, 1, 30'h1000, 8'd15};
        tv[2]  = '{30'h0,   30'h200,    30'h1000, 30'h1100, 8'd15,  2'b11, 10'd20,   10'd20, 1'b1, 0, 30'h0,    8'd15};
        tv[3]  = '{30'h0,   30'h200,    30'h1000, 30'h1100, 8'd15,  2'b10, 10'd20,   10'd20, 1'b1, 1, 30'h1000, 8'd15};
        tv[4]  = '{30'h0,   30'h40,     30'h1000, 30'h1100, 8'd15,  2'b11, 10'd20,   10'd0,  1'b1, 0, 30'h0,    8'd7};
        tv[5]  = '{30'h0,   30'h40,     30'h1000, 30'h1100, 8'd15,  2'b11, 10'd8,    10'd0,  1'b1, 0, 30'h0,    8'd7};
        tv[6]  = '{30'h0,   30'h40,     30'h1000, 30'h1100, 8'd15,  2'b11, 10'd7,    10'd0,  1'b0, 0, 30'h0,    8'd0};
        tv[7]  = '{30'h0,   30'h200,    30'h1000, 30'h1100, 8'd15,  2'b11, 10'd15,   10'd0,  1'b0, 0, 30'h0,    8'd0};
        tv[8]  = '{30'h0,   30'h200,    30'h1000, 30'h1100, 8'd15,  2'b00, 10'd40,   10'd40, 1'b0, 0, 30'h0,    8'd0};
        tv[9]  = '{30'h200, 30'h200,    30'h1000, 30'h1100, 8'd15,  2'b01, 10'd40,   10'd0,  1'b0, 0, 30'h0,    8'd0};
        tv[10] = '{30'h0,   30'h200,    30'h1000, 30'h1100, 8'd3,   2'b11, 10'd4,    10'd0,  1'b1, 0, 30'h0,    8'd3};
        tv[11] = '{30'h0,   30'h100000, 30'h1000, 30'h1100, 8'd255, 2'b01, 10'd1023, 10'd0,  1'b1, 0, 30'h0,    8'd255};
        tv[12] = '{30'hFC0, 30'h2000,   30'h1000, 30'h1100, 8'd15,  2'b01, 10'd20,   10'd0,  1'b1, 0, 30'hFC0,  L4K};
        tv[13] = '{30'h100, 30'h80,     30'h1000, 30'h1100, 8'd15,  2'b01, 10'd40,   10'd0,  1'b0, 0, 30'h0,    8'd0};

        for (int i = 0; i < 14; i++) begin
            if (tv[i].go) push(tv[i].ch, tv[i].addr, tv[i].len);
            rst_apply(tv[i].b0, tv[i].e0, tv[i].b1, tv[i].e1, tv[i].bl, tv[i].en, tv[i].l0, tv[i].l1);
            if (tv[i].go) begin
                wait_acc(acc_cnt + 1, 40);
                ch_en = '0;
                wait_idle(400);
            end else
                no_start("no_start_vec", 30);
        end

        push(0, 30'h0, 8'd15);
        push(1, 30'h1000, 8'd15);
        push(0, 30'h80, 8'd15);
        push(1, 30'h1080, 8'd15);
        rst_apply(30'h0, 30'h200, 30'h1000, 30'h1100, 8'd15, 2'b11, 10'd40, 10'd40);
        wait_acc(acc_cnt + 4, 200);
        ch_en = '0;
        wait_idle(100);

        push(0, 30'h0, 8'd15);
        push(0, 30'h80, 8'd15);
        push(0, 30'h100, 8'd15);
        push(0, 30'h180, 8'd13);
        push(0, 30'h0, 8'd15);
        rst_apply(30'h0, 30'h1F0, 30'h1000, 30'h1100, 8'd15, 2'b01, 10'd40, 10'd0);
        wait_acc(acc_cnt + 5, 250);
        ch_en = '0;
        wait_idle(100);

        rst_apply(30'h0, 30'h200, 30'h1000, 30'h1100, 8'd15, 2'b01, 10'd15, 10'd0);
        no_start("no_start_lvl15", 20);
        push(0, 30'h0, 8'd15);
        @(posedge clk);
        #1 fifo_level[9:0] = 10'd16;
        @(posedge clk);
        #1 chk("start_lat_cyc1", 64'(m_start), 0);
        @(posedge clk);
        #1 chk("start_lat_cyc2", 64'(m_start), 1);
        wait_acc(acc_cnt + 1, 10);
        ch_en = 2'b10;
        wait_idle(100);
        fifo_level[9:0] = 10'd40;
        no_start("no_start_ch_en0", 30);

        push(0, 30'h0, 8'd15);
        rst_apply(30'h0, 30'h200, 30'h1000, 30'h1100, 8'd15, 2'b01, 10'd40, 10'd0);
        wait_acc(acc_cnt + 1, 20);
        ch_en = '0;
        repeat (4) @(posedge clk);
        #1 ch_clr = 2'b01;
        @(posedge clk);
        #1 ch_clr = 2'b00;
        wait_idle(100);
        push(0, 30'h0, 8'd15);
        ch_en = 2'b01;
        wait_acc(acc_cnt + 1, 20);
        ch_en = '0;
        wait_idle(100);

        rst_apply(30'h0, 30'h200, 30'h1000, 30'h1100, 8'd15, 2'b01, 10'd40, 10'd0);
        mst_en = 1'b0;
        k = 0;
        while (!m_start && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        chk("req_reached", 64'(m_start), 1);
        rst_n = 1'b0;
        #1 chk("async_rst_outs", 64'({m_start, busy, ch_sel, m_len, m_ch, m_addr}), 0);
        ch_en = '0;
        @(posedge clk);
        #1 mst_en = 1'b1;
        rst_n = 1'b1;
        no_start("no_start_after_rst", 10);

        chk("sb_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
